// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: serialises the LC-3b instruction-fetch port (I) and the MEM-stage data port (D)
// onto one physical memory that uses a read/write/resp handshake.
//
// Ports:
//   clk, reset_n                 clock (rising edge), asynchronous active-low reset
//   i_addr, i_read               fetch request (level, held until i_resp)
//   i_rdata, i_resp              fetch data and one-cycle completion pulse
//   d_addr, d_read, d_write,     data request (level); write wins if both strobes are high
//   d_wdata, d_byte_en
//   d_rdata, d_resp              data read data and one-cycle completion pulse
//   pmem_addr, pmem_read,        registered physical memory command, held for the whole
//   pmem_write, pmem_wdata,      transaction
//   pmem_byte_en
//   pmem_rdata, pmem_resp        physical memory read data and completion
//
// D normally wins a tie. After STARVE_LIMIT consecutive D grants made while I was waiting,
// I is forced ahead.
module lc3b_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] i_addr,
  input  logic        i_read,
  output logic [15:0] i_rdata,
  output logic        i_resp,
  input  logic [15:0] d_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_byte_en,
  output logic [15:0] d_rdata,
  output logic        d_resp,
  output logic [15:0] pmem_addr,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_en,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [15:0] addr_q, addr_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  // Last delivered data per port; shown whenever that port is not completing.
  logic [15:0] i_hold_q, i_hold_d;
  logic [15:0] d_hold_q, d_hold_d;

  logic d_req, starved, grant_i, grant_d;

  assign d_req   = d_read | d_write;
  assign starved = (streak_q == Limit);
  assign grant_i = i_read & (~d_req | starved);
  assign grant_d = d_req & ~grant_i;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    read_d   = read_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    i_hold_d = i_hold_q;
    d_hold_d = d_hold_q;
    unique case (state_q)
      StIdle: begin
        if (grant_i) begin
          state_d  = StServeI;
          addr_d   = i_addr;
          read_d   = 1'b1;
          write_d  = 1'b0;
          wdata_d  = 16'h0000;
          be_d     = 2'b11;
          streak_d = 4'd0;
        end else if (grant_d) begin
          state_d  = StServeD;
          addr_d   = d_addr;
          read_d   = ~d_write;
          write_d  = d_write;
          wdata_d  = d_wdata;
          be_d     = d_byte_en;
          // Only D grants that bypass a waiting fetch count toward starvation.
          if (i_read) begin
            streak_d = (streak_q >= Limit) ? Limit : streak_q + 4'd1;
          end else begin
            streak_d = 4'd0;
          end
        end
      end
      StServeI: begin
        if (pmem_resp) begin
          state_d  = StIdle;
          read_d   = 1'b0;
          write_d  = 1'b0;
          i_hold_d = pmem_rdata;
        end
      end
      StServeD: begin
        if (pmem_resp) begin
          state_d  = StIdle;
          read_d   = 1'b0;
          write_d  = 1'b0;
          d_hold_d = pmem_rdata;
        end
      end
      default: begin
        state_d = StIdle;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      streak_q <= 4'd0;
      addr_q   <= 16'h0000;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= 16'h0000;
      be_q     <= 2'b00;
      i_hold_q <= 16'h0000;
      d_hold_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      read_q   <= read_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      i_hold_q <= i_hold_d;
      d_hold_q <= d_hold_d;
    end
  end

  // Completion is routed combinationally to the owner only; stray responses in idle are ignored.
  always_comb begin
    i_resp  = (state_q == StServeI) & pmem_resp;
    d_resp  = (state_q == StServeD) & pmem_resp;
    i_rdata = i_resp ? pmem_rdata : i_hold_q;
    d_rdata = d_resp ? pmem_rdata : d_hold_q;
  end

  assign pmem_addr    = addr_q;
  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_wdata   = wdata_q;
  assign pmem_byte_en = be_q;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Bench for lc3b_mem_arbiter: memory model, response scoreboard, a vector table and
// hand-written sequences for tie-break, starvation, reset and stray-response corners.
module tb_lc3b_mem_arbiter;

  logic        clk, reset_n;
  logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic        i_read, i_resp, d_read, d_write, d_resp;
  logic [1:0]  d_byte_en, pmem_byte_en;
  logic [15:0] pmem_addr, pmem_wdata, pmem_rdata;
  logic        pmem_read, pmem_write, pmem_resp;

  logic        mdl_resp, man_resp, mem_en;
  logic [15:0] mdl_rdata, man_rdata;
  int          mem_lat;

  assign pmem_resp  = mdl_resp | man_resp;
  assign pmem_rdata = man_resp ? man_rdata : mdl_rdata;

  lc3b_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_byte_en(pmem_byte_en),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [15:0] i_q[$];
  logic [15:0] d_q[$];
  byte         log_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return (a == 16'h0040) ? 16'h1234 : (a ^ 16'hA5C3);
  endfunction

  // Memory model: answers mem_lat cycles after the strobe first appears.
  initial begin
    int cnt;
    cnt = 0;
    mdl_resp = 1'b0;
    mdl_rdata = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en && (pmem_read || pmem_write)) begin
        if (cnt == mem_lat) begin
          mdl_resp  = 1'b1;
          mdl_rdata = mem_data(pmem_addr);
        end else begin
          mdl_resp = 1'b0;
        end
        cnt++;
      end else begin
        mdl_resp = 1'b0;
        cnt = 0;
      end
    end
  end

  // Scoreboard monitor plus per-cycle exclusivity checks.
  logic [15:0] mon_e;
  always @(negedge clk) begin
    if (reset_n) begin
      chk("one_strobe", {31'd0, pmem_read & pmem_write}, 32'd0);
      chk("one_resp", {31'd0, i_resp & d_resp}, 32'd0);
      if (i_resp) begin
        log_q.push_back(8'h49);
        if (i_q.size() == 0) chk("i_resp_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = i_q.pop_front();
          chk("i_rdata", {16'd0, i_rdata}, {16'd0, mon_e});
        end
      end
      if (d_resp) begin
        log_q.push_back(8'h44);
        if (d_q.size() == 0) chk("d_resp_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = d_q.pop_front();
          chk("d_rdata", {16'd0, d_rdata}, {16'd0, mon_e});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    i_read = 1'b0;
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic do_reset();
    drop_all();
    man_resp = 1'b0;
    mem_en = 1'b1;
    reset_n = 1'b0;
    i_q.delete();
    d_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
  endtask

  // Returns with found set at the negedge of the completion cycle; cycles counts edges waited.
  task automatic wait_resp(input bit port_i, input int budget, output int cycles, output bit found);
    found = 1'b0;
    cycles = 0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (port_i ? i_resp : d_resp) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  typedef struct {
    logic        i_read, d_read, d_write;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [1:0]  d_be;
    int          lat;
    logic        exp_rd, exp_wr, exp_i, chk_wdata;
    logic [15:0] exp_addr, exp_wdata;
    logic [1:0]  exp_be;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int  cyc;
    bit  found;
    int  nd, ni;
    bit  gi, gd;
    byte exp_log[7];

    //           ird dr  dw  i_addr    d_addr    d_wdata   be     lat rd  wr  I   cw  addr      wdata     be
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000, 2'b00, 2, 1'b1, 1'b0, 1'b1, 1'b0,
                16'h0040, 16'h0000, 2'b11};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h2000, 16'h1111, 2'b10, 0, 1'b1, 1'b0, 1'b0, 1'b0,
                16'h2000, 16'h0000, 2'b10};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h3001, 16'hBEEF, 2'b01, 1, 1'b0, 1'b1, 1'b0, 1'b1,
                16'h3001, 16'hBEEF, 2'b01};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0042, 16'h2004, 16'h0000, 2'b11, 0, 1'b1, 1'b0, 1'b0, 1'b0,
                16'h2004, 16'h0000, 2'b11};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h2ABC, 16'h1357, 2'b10, 3, 1'b0, 1'b1, 1'b0, 1'b1,
                16'h2ABC, 16'h1357, 2'b10};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 2'b00, 1, 1'b1, 1'b0, 1'b1, 1'b0,
                16'h0100, 16'h0000, 2'b11};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 16'h0102, 16'h2F00, 16'h0F0F, 2'b11, 0, 1'b0, 1'b1, 1'b0, 1'b1,
                16'h2F00, 16'h0F0F, 2'b11};

    reset_n = 1'b0;
    drop_all();
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0; d_byte_en = 2'b00;
    man_resp = 1'b0; man_rdata = 16'h0; mem_en = 1'b1; mem_lat = 0;

    // Reset state.
    #3;
    chk("rst_pmem_addr", {16'd0, pmem_addr}, 32'd0);
    chk("rst_pmem_read", {31'd0, pmem_read}, 32'd0);
    chk("rst_pmem_write", {31'd0, pmem_write}, 32'd0);
    chk("rst_pmem_wdata", {16'd0, pmem_wdata}, 32'd0);
    chk("rst_pmem_be", {30'd0, pmem_byte_en}, 32'd0);
    chk("rst_i_resp", {31'd0, i_resp}, 32'd0);
    chk("rst_d_resp", {31'd0, d_resp}, 32'd0);
    chk("rst_i_rdata", {16'd0, i_rdata}, 32'd0);
    chk("rst_d_rdata", {16'd0, d_rdata}, 32'd0);
    do_reset();

    // Vector table: one transaction each, starting and ending in idle.
    for (int v = 0; v < 7; v++) begin
      i_read = vecs[v].i_read; d_read = vecs[v].d_read; d_write = vecs[v].d_write;
      i_addr = vecs[v].i_addr; d_addr = vecs[v].d_addr; d_wdata = vecs[v].d_wdata;
      d_byte_en = vecs[v].d_be; mem_lat = vecs[v].lat;
      if (vecs[v].exp_i) i_q.push_back(mem_data(vecs[v].exp_addr));
      else d_q.push_back(mem_data(vecs[v].exp_addr));
      tick();
      chk($sformatf("v%0d_pmem_read", v), {31'd0, pmem_read}, {31'd0, vecs[v].exp_rd});
      chk($sformatf("v%0d_pmem_write", v), {31'd0, pmem_write}, {31'd0, vecs[v].exp_wr});
      chk($sformatf("v%0d_pmem_addr", v), {16'd0, pmem_addr}, {16'd0, vecs[v].exp_addr});
      chk($sformatf("v%0d_pmem_be", v), {30'd0, pmem_byte_en}, {30'd0, vecs[v].exp_be});
      if (vecs[v].chk_wdata)
        chk($sformatf("v%0d_pmem_wdata", v), {16'd0, pmem_wdata}, {16'd0, vecs[v].exp_wdata});
      // Mid-transaction changes must not reach memory.
      i_addr = ~i_addr; d_addr = ~d_addr; d_wdata = ~d_wdata; d_byte_en = ~d_byte_en;
      wait_resp(vecs[v].exp_i, 20, cyc, found);
      chk($sformatf("v%0d_resp_seen", v), {31'd0, found}, 32'd1);
      chk($sformatf("v%0d_resp_cycle", v), cyc, vecs[v].lat);
      chk($sformatf("v%0d_addr_held", v), {16'd0, pmem_addr}, {16'd0, vecs[v].exp_addr});
      tick();
      drop_all();
      chk($sformatf("v%0d_strobe_off", v), {31'd0, pmem_read | pmem_write}, 32'd0);
      tick();
    end

    // Tie with streak=0: D first, I granted in the idle cycle after d_resp.
    do_reset();
    mem_lat = 1;
    i_read = 1'b1; i_addr = 16'h0042; d_read = 1'b1; d_addr = 16'h2000;
    d_q.push_back(mem_data(16'h2000));
    i_q.push_back(mem_data(16'h0042));
    wait_resp(1'b0, 20, cyc, found);
    chk("tie_d_first", {31'd0, found}, 32'd1);
    chk("tie_i_rdata_hold", {16'd0, i_rdata}, 32'd0);
    tick();
    d_read = 1'b0;
    chk("tie_idle_gap", {31'd0, pmem_read | pmem_write}, 32'd0);
    tick();
    chk("tie_i_strobe", {31'd0, pmem_read}, 32'd1);
    chk("tie_i_addr", {16'd0, pmem_addr}, 32'h0042);
    wait_resp(1'b1, 20, cyc, found);
    chk("tie_i_done", {31'd0, found}, 32'd1);
    chk("tie_d_rdata_hold", {16'd0, d_rdata}, {16'd0, mem_data(16'h2000)});
    tick();
    drop_all();
    tick();

    // Starvation: I waits while D streams six reads.
    do_reset();
    mem_lat = 0;
    log_q.delete();
    i_read = 1'b1; i_addr = 16'h0050; d_read = 1'b1; d_addr = 16'h2100;
    i_q.push_back(mem_data(16'h0050));
    for (int k = 0; k < 6; k++) d_q.push_back(mem_data(16'h2100));
    nd = 0;
    ni = 0;
    for (int t = 0; t < 100 && (nd < 6 || ni < 1); t++) begin
      @(negedge clk);
      gi = i_resp;
      gd = d_resp;
      tick();
      if (gd) begin
        nd++;
        if (nd == 6) d_read = 1'b0;
      end
      if (gi) begin
        ni++;
        i_read = 1'b0;
        chk("starve_streak_clear", {28'd0, dut.streak_q}, 32'd0);
      end
    end
    chk("starve_done", {31'd0, (nd == 6 && ni == 1)}, 32'd1);
    exp_log = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44, 8'h44};
    chk("starve_log_len", log_q.size(), 32'd7);
    for (int k = 0; k < 7 && k < log_q.size(); k++)
      chk($sformatf("starve_order%0d", k), {24'd0, log_q[k]}, {24'd0, exp_log[k]});
    drop_all();
    tick();

    // Asynchronous reset mid-transaction.
    do_reset();
    mem_en = 1'b0;
    d_read = 1'b1; d_addr = 16'h2200;
    tick();
    chk("rstmid_strobe_on", {31'd0, pmem_read}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstmid_strobe_off", {31'd0, pmem_read}, 32'd0);
    chk("rstmid_addr_clr", {16'd0, pmem_addr}, 32'd0);
    d_read = 1'b0;
    tick();
    reset_n = 1'b1;
    man_resp = 1'b1; man_rdata = 16'hBAD0;
    @(negedge clk);
    chk("rstmid_late_d_resp", {31'd0, d_resp}, 32'd0);
    chk("rstmid_late_i_resp", {31'd0, i_resp}, 32'd0);
    tick();
    man_resp = 1'b0;
    mem_en = 1'b1;
    mem_lat = 1;
    i_read = 1'b1; i_addr = 16'h0060;
    i_q.push_back(mem_data(16'h0060));
    tick();
    chk("postrst_strobe", {31'd0, pmem_read}, 32'd1);
    chk("postrst_addr", {16'd0, pmem_addr}, 32'h0060);
    wait_resp(1'b1, 20, cyc, found);
    chk("postrst_done", {31'd0, found}, 32'd1);
    tick();
    drop_all();
    tick();

    // Stray response in idle.
    man_resp = 1'b1; man_rdata = 16'h7777;
    @(negedge clk);
    chk("stray_i_resp", {31'd0, i_resp}, 32'd0);
    chk("stray_d_resp", {31'd0, d_resp}, 32'd0);
    chk("stray_i_rdata_hold", {16'd0, i_rdata}, {16'd0, mem_data(16'h0060)});
    tick();
    man_resp = 1'b0;
    chk("stray_stay_idle", {31'd0, pmem_read | pmem_write}, 32'd0);
    tick();
    chk("end_i_q_empty", i_q.size(), 32'd0);
    chk("end_d_q_empty", d_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
